// File: rtl/router_nport_if.sv
// Packet-source and per-port consumer signals of router_nport, bundled as one interface.
// The master side drives the packet stream and the pop requests; the slave side is the router.
interface router_nport_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 3
);
    logic                          pkt_valid;
    logic [DATA_W-1:0]             data_in;
    logic                          busy;
    logic                          err;
    logic                          drop;
    logic [NUM_PORTS-1:0]          read_enb;
    logic [NUM_PORTS-1:0]          vld_out;
    logic [NUM_PORTS*DATA_W-1:0]   data_out;
    logic [NUM_PORTS-1:0]          soft_reset;

    modport master (
        output pkt_valid, data_in, read_enb,
        input  busy, err, drop, vld_out, data_out, soft_reset
    );

    modport slave (
        input  pkt_valid, data_in, read_enb,
        output busy, err, drop, vld_out, data_out, soft_reset
    );
endinterface

// File: rtl/router_nport.sv
// Byte-serial packet router: one input stream is steered by header address into NUM_PORTS
// FIFOs. A packet is admitted only if it fits whole, and each port flushes itself after a read timeout.
module router_nport #(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 3,
    parameter int DEPTH     = 128,
    parameter int TIMEOUT   = 30
) (
    input logic           clock,
    input logic           resetn,
    router_nport_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DROP} state_t;

    state_t               state, state_next;
    logic [1:0]           dest, dest_next;
    logic [DATA_W-1:0]    acc, acc_next;
    logic                 err_q, err_next;
    logic [NUM_PORTS-1:0] soft_q;

    logic [AW-1:0]        wr_ptr [NUM_PORTS];
    logic [AW-1:0]        rd_ptr [NUM_PORTS];
    logic [CW-1:0]        count  [NUM_PORTS];
    logic [TW-1:0]        tmo    [NUM_PORTS];
    logic [DATA_W-1:0]    dout   [NUM_PORTS];
    logic [DATA_W-1:0]    mem    [NUM_PORTS][DEPTH];

    logic [NUM_PORTS-1:0] push, pop, flush, full, hdr_sel, dest_sel;
    logic [1:0]           hdr_addr;
    logic [DATA_W-3:0]    hdr_len;
    logic [CW-1:0]        hdr_count;
    logic                 dest_full, dest_flush, addr_ok, fits, busy_c, drop_c;

    assign hdr_addr = bus.data_in[1:0];
    assign hdr_len  = bus.data_in[DATA_W-1:2];

    // A flush fires on the TIMEOUT-th consecutive cycle a non-empty port goes unread.
    always_comb begin
        hdr_count  = '0;
        dest_full  = 1'b0;
        dest_flush = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            full[p]     = (count[p] == CW'(DEPTH));
            pop[p]      = bus.read_enb[p] && (count[p] != '0);
            flush[p]    = (count[p] != '0) && !bus.read_enb[p] && (tmo[p] == TW'(TIMEOUT - 1));
            hdr_sel[p]  = (hdr_addr == 2'(p));
            dest_sel[p] = (dest == 2'(p));
            if (hdr_sel[p]) hdr_count = count[p];
            if (dest_sel[p]) begin
                dest_full  = full[p];
                dest_flush = flush[p];
            end
        end
    end

    always_comb begin
        state_next = state;
        dest_next  = dest;
        acc_next   = acc;
        err_next   = err_q;
        push       = '0;
        busy_c     = 1'b0;
        drop_c     = 1'b0;
        addr_ok    = 32'(hdr_addr) < NUM_PORTS;
        fits       = (DEPTH - 32'(hdr_count)) >= (32'(hdr_len) + 32'd2);
        case (state)
            IDLE: begin
                if (bus.pkt_valid) begin
                    if (!addr_ok) begin
                        drop_c     = 1'b1;
                        state_next = DROP;
                    end else if (!fits) begin
                        busy_c = 1'b1;
                    end else begin
                        push       = hdr_sel;
                        acc_next   = bus.data_in;
                        err_next   = 1'b0;
                        dest_next  = hdr_addr;
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                // A flush of the destination abandons the packet; the byte on the bus is lost.
                if (dest_flush) begin
                    state_next = bus.pkt_valid ? DROP : IDLE;
                end else if (dest_full) begin
                    busy_c = 1'b1;
                end else if (bus.pkt_valid) begin
                    push     = dest_sel;
                    acc_next = acc ^ bus.data_in;
                end else begin
                    push       = dest_sel;
                    err_next   = (acc != bus.data_in);
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (!bus.pkt_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            dest  <= '0;
            acc   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            dest  <= dest_next;
            acc   <= acc_next;
            err_q <= err_next;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            soft_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
                tmo[p]    <= '0;
                dout[p]   <= '0;
            end
        end else begin
            soft_q <= flush;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (flush[p]) begin
                    wr_ptr[p] <= '0;
                    rd_ptr[p] <= '0;
                    count[p]  <= '0;
                    tmo[p]    <= '0;
                end else begin
                    if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
                    if (pop[p]) begin
                        rd_ptr[p] <= rd_ptr[p] + AW'(1);
                        dout[p]   <= mem[p][rd_ptr[p]];
                    end
                    if (push[p] && !pop[p]) count[p] <= count[p] + CW'(1);
                    else if (pop[p] && !push[p]) count[p] <= count[p] - CW'(1);
                    if (bus.read_enb[p] || count[p] == '0) tmo[p] <= '0;
                    else tmo[p] <= tmo[p] + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p] && !flush[p]) mem[p][wr_ptr[p]] <= bus.data_in;
        end
    end

    // busy and drop are masked by reset so every output reads 0 while resetn is low.
    always_comb begin
        bus.busy       = busy_c & resetn;
        bus.drop       = drop_c & resetn;
        bus.err        = err_q;
        bus.soft_reset = soft_q;
        bus.vld_out    = '0;
        bus.data_out   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.vld_out[p]                   = (count[p] != '0);
            bus.data_out[p*DATA_W +: DATA_W] = dout[p];
        end
    end
endmodule

// File: tb/tb_router_nport.sv
// Self-checking bench for router_nport: per-port scoreboard queues are filled as bytes are
// routed and emptied as the consumers pop them.
module tb_router_nport;
    localparam int DATA_W    = 8;
    localparam int NUM_PORTS = 3;
    localparam int DEPTH     = 8;
    localparam int TIMEOUT   = 30;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [DATA_W-1:0] exp_q [NUM_PORTS][$];

    router_nport_if #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS)) bus ();

    router_nport #(
        .DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one byte from posedge+1; waits out busy (bounded) and returns after the consuming edge.
    task automatic send_byte(input logic v, input logic [7:0] d, input int max_stall,
                             output int stalls, output logic saw_drop);
        bus.pkt_valid = v;
        bus.data_in   = d;
        stalls        = 0;
        @(negedge clock);
        while (bus.busy === 1'b1 && stalls < max_stall) begin
            @(negedge clock);
            stalls++;
        end
        saw_drop = bus.drop;
        @(posedge clock);
        #1;
    endtask

    task automatic pop_once(input int p, output logic [7:0] got, output logic [7:0] want);
        bus.read_enb[p] = 1'b1;
        step();
        bus.read_enb[p] = 1'b0;
        got  = bus.data_out[p*DATA_W +: DATA_W];
        want = (exp_q[p].size() != 0) ? exp_q[p].pop_front() : 8'hxx;
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.drop !== 1'b0 || bus.vld_out !== 3'b000 ||
            bus.soft_reset !== 3'b000 || bus.data_out !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got busy=%b err=%b drop=%b vld=%b soft=%b dout=%h, expected all 0",
                     bus.busy, bus.err, bus.drop, bus.vld_out, bus.soft_reset, bus.data_out);
        end
        step();
        step();
        resetn = 1'b1;
        step();
        tests_run++;
        if (bus.vld_out !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_vld: got %b, expected 000", bus.vld_out);
        end
    endtask

    task automatic test_routed();
        int st, st_sum;
        logic dr;
        logic [7:0] got, want;
        logic [7:0] bytes [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        st_sum = 0;
        for (int i = 0; i < 5; i++) begin
            send_byte(i < 4, bytes[i], 4, st, dr);
            st_sum += st;
            if (st < 4) exp_q[1].push_back(bytes[i]);
            if (i == 0) begin
                tests_run++;
                if (bus.vld_out !== 3'b010) begin
                    tests_failed++;
                    $display("[TB] FAIL routed_vld_after_hdr: got %b, expected 010", bus.vld_out);
                end
            end
        end
        tests_run++;
        if (st_sum !== 0 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL routed_busy_err: got stalls=%0d err=%b, expected 0 and 0", st_sum, bus.err);
        end
        for (int i = 0; i < 5; i++) begin
            pop_once(1, got, want);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL routed_pop%0d: got %h, expected %h", i, got, want);
            end
        end
        tests_run++;
        if (bus.vld_out !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL routed_empty: got %b, expected 000", bus.vld_out);
        end
    endtask

    task automatic test_bad_parity();
        int st;
        logic dr;
        logic [7:0] got, want;
        logic [7:0] bytes [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        for (int i = 0; i < 5; i++) begin
            send_byte(i < 4, bytes[i], 4, st, dr);
            if (st < 4) exp_q[1].push_back(bytes[i]);
        end
        tests_run++;
        if (bus.err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL badpar_err: got %b, expected 1", bus.err);
        end
        for (int i = 0; i < 5; i++) begin
            pop_once(1, got, want);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL badpar_pop%0d: got %h, expected %h", i, got, want);
            end
        end
        tests_run++;
        if (bus.err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL badpar_err_hold: got %b, expected 1", bus.err);
        end
    endtask

    task automatic test_invalid_addr();
        int st, st_sum, drops;
        logic dr;
        logic [7:0] bytes [3] = '{8'h07, 8'h55, 8'h99};
        st_sum = 0;
        drops  = 0;
        for (int i = 0; i < 3; i++) begin
            send_byte(i < 2, bytes[i], 4, st, dr);
            st_sum += st;
            if (dr === 1'b1) drops++;
            tests_run++;
            if (bus.vld_out !== 3'b000) begin
                tests_failed++;
                $display("[TB] FAIL invalid_vld%0d: got %b, expected 000", i, bus.vld_out);
            end
        end
        tests_run++;
        if (drops !== 1 || st_sum !== 0) begin
            tests_failed++;
            $display("[TB] FAIL invalid_drop: got drops=%0d stalls=%0d, expected 1 and 0", drops, st_sum);
        end
        tests_run++;
        if (bus.err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL invalid_err_unchanged: got %b, expected 1", bus.err);
        end
    endtask

    task automatic test_err_clear();
        int st;
        logic dr;
        logic [7:0] got, want;
        logic [7:0] bytes [3] = '{8'h05, 8'hAA, 8'hAF};
        for (int i = 0; i < 3; i++) begin
            send_byte(i < 2, bytes[i], 4, st, dr);
            if (st < 4) exp_q[1].push_back(bytes[i]);
            if (i == 0) begin
                tests_run++;
                if (bus.err !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL errclr_on_accept: got %b, expected 0", bus.err);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            pop_once(1, got, want);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL errclr_pop%0d: got %h, expected %h", i, got, want);
            end
        end
        tests_run++;
        if (bus.err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL errclr_good_parity: got %b, expected 0", bus.err);
        end
    endtask

    task automatic test_space_check();
        int st;
        logic dr;
        logic [7:0] got, want;
        logic [7:0] first [4]  = '{8'h08, 8'h01, 8'h02, 8'h0B};
        logic [7:0] second [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hDC};
        for (int i = 0; i < 4; i++) begin
            send_byte(i < 3, first[i], 4, st, dr);
            if (st < 4) exp_q[0].push_back(first[i]);
        end
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h0C;
        @(negedge clock);
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL space_busy: got %b, expected 1", bus.busy);
        end
        step();
        bus.read_enb[0] = 1'b1;
        @(negedge clock);
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL space_pop_not_credited: got %b, expected 1", bus.busy);
        end
        step();
        bus.read_enb[0] = 1'b0;
        got  = bus.data_out[7:0];
        want = exp_q[0].pop_front();
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL space_pop: got %h, expected %h", got, want);
        end
        @(negedge clock);
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL space_release: got %b, expected 0", bus.busy);
        end
        step();
        exp_q[0].push_back(8'h0C);
        for (int i = 0; i < 4; i++) begin
            send_byte(i < 3, second[i], 4, st, dr);
            if (st < 4) exp_q[0].push_back(second[i]);
            tests_run++;
            if (st !== 0) begin
                tests_failed++;
                $display("[TB] FAIL space_body_stall%0d: got %0d, expected 0", i, st);
            end
        end
        for (int i = 0; i < 8; i++) begin
            pop_once(0, got, want);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL space_drain%0d: got %h, expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        int st, st_sum;
        logic dr;
        logic [7:0] got, want;
        logic [7:0] pa [3] = '{8'h04, 8'h10, 8'h14};
        logic [7:0] pb [3] = '{8'h04, 8'h30, 8'h34};
        st_sum = 0;
        for (int i = 0; i < 3; i++) begin
            send_byte(i < 2, pa[i], 4, st, dr);
            st_sum += st;
            if (st < 4) exp_q[0].push_back(pa[i]);
        end
        bus.read_enb[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_byte(i < 2, pb[i], 4, st, dr);
            st_sum += st;
            if (st < 4) exp_q[0].push_back(pb[i]);
            got  = bus.data_out[7:0];
            want = exp_q[0].pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL b2b_pushpop%0d: got %h, expected %h", i, got, want);
            end
        end
        bus.read_enb[0] = 1'b0;
        tests_run++;
        if (st_sum !== 0 || bus.vld_out !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL b2b_flow: got stalls=%0d vld=%b, expected 0 and 001", st_sum, bus.vld_out);
        end
        for (int i = 0; i < 3; i++) begin
            pop_once(0, got, want);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL b2b_drain%0d: got %h, expected %h", i, got, want);
            end
        end
        tests_run++;
        if (bus.vld_out !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL b2b_empty: got %b, expected 000", bus.vld_out);
        end
    endtask

    task automatic test_timeout();
        int st, pulses, pulse_k;
        logic dr;
        logic [7:0] got, want;
        send_byte(1'b1, 8'h02, 4, st, dr);
        send_byte(1'b0, 8'h02, 4, st, dr);
        pulses  = 0;
        pulse_k = -1;
        for (int k = 2; k <= 33; k++) begin
            step();
            if (bus.soft_reset[2] === 1'b1) begin
                pulses++;
                pulse_k = k;
            end
        end
        tests_run++;
        if (pulses !== 1 || pulse_k !== 30 || bus.vld_out !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL timeout_flush: got pulses=%0d at k=%0d vld=%b, expected 1 at k=30 vld=000",
                     pulses, pulse_k, bus.vld_out);
        end
        exp_q[2].delete();

        send_byte(1'b1, 8'h02, 4, st, dr);
        exp_q[2].push_back(8'h02);
        send_byte(1'b0, 8'h02, 4, st, dr);
        exp_q[2].push_back(8'h02);
        pulses  = 0;
        pulse_k = -1;
        for (int k = 2; k <= 28; k++) begin
            step();
            if (bus.soft_reset[2] === 1'b1) pulses++;
        end
        pop_once(2, got, want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL timeout_read29: got %h, expected %h", got, want);
        end
        for (int k = 30; k <= 62; k++) begin
            step();
            if (bus.soft_reset[2] === 1'b1) begin
                pulses++;
                pulse_k = k;
            end
        end
        tests_run++;
        if (pulses !== 1 || pulse_k !== 59 || bus.vld_out !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL timeout_restart: got pulses=%0d at k=%0d vld=%b, expected 1 at k=59 vld=000",
                     pulses, pulse_k, bus.vld_out);
        end
        exp_q[2].delete();
    endtask

    task automatic test_flush_in_load();
        int st;
        logic dr;
        logic [7:0] got, want;
        logic [7:0] next_pkt [3] = '{8'h06, 8'h5A, 8'h5C};
        send_byte(1'b1, 8'h02, 4, st, dr);
        for (int i = 0; i < 7; i++) send_byte(1'b1, 8'h40 + 8'(i), 4, st, dr);
        send_byte(1'b1, 8'h47, 40, st, dr);
        tests_run++;
        if (st >= 40 || bus.soft_reset[2] !== 1'b1 || bus.vld_out[2] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_flush: got stalls=%0d soft=%b vld2=%b, expected <40, 1, 0",
                     st, bus.soft_reset[2], bus.vld_out[2]);
        end
        exp_q[2].delete();
        send_byte(1'b1, 8'h48, 4, st, dr);
        send_byte(1'b0, 8'h00, 4, st, dr);
        tests_run++;
        if (bus.vld_out !== 3'b000 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_discard: got vld=%b err=%b, expected 000 and 0", bus.vld_out, bus.err);
        end
        for (int i = 0; i < 3; i++) begin
            send_byte(i < 2, next_pkt[i], 4, st, dr);
            if (st < 4) exp_q[2].push_back(next_pkt[i]);
        end
        for (int i = 0; i < 3; i++) begin
            pop_once(2, got, want);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL load_next_pop%0d: got %h, expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        int st;
        logic dr;
        logic [7:0] got, want;
        logic [7:0] bytes [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_byte(1'b1, 8'h0D, 4, st, dr);
        send_byte(1'b1, 8'h11, 4, st, dr);
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h33;
        resetn        = 1'b0;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.drop !== 1'b0 || bus.vld_out !== 3'b000 ||
            bus.soft_reset !== 3'b000 || bus.data_out !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: got busy=%b err=%b drop=%b vld=%b soft=%b dout=%h, expected all 0",
                     bus.busy, bus.err, bus.drop, bus.vld_out, bus.soft_reset, bus.data_out);
        end
        for (int p = 0; p < NUM_PORTS; p++) exp_q[p].delete();
        step();
        bus.pkt_valid = 1'b0;
        resetn        = 1'b1;
        step();
        tests_run++;
        if (bus.vld_out !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL midreset_vld: got %b, expected 000", bus.vld_out);
        end
        for (int i = 0; i < 5; i++) begin
            send_byte(i < 4, bytes[i], 4, st, dr);
            if (st < 4) exp_q[1].push_back(bytes[i]);
        end
        for (int i = 0; i < 5; i++) begin
            pop_once(1, got, want);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL midreset_pop%0d: got %h, expected %h", i, got, want);
            end
        end
    endtask

    initial begin
        bus.pkt_valid = 1'b0;
        bus.data_in   = '0;
        bus.read_enb  = '0;
        #2 resetn = 1'b0;
        #1;
        test_reset();
        test_routed();
        test_bad_parity();
        test_invalid_addr();
        test_err_clear();
        test_space_check();
        test_back_to_back();
        test_timeout();
        test_flush_in_load();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
